// File: rtl/bus_xfer_ctrl.sv
// Burst transfer controller: latches a one-hot arbiter grant, muxes the owning master's beats downstream, acks on completion.
// Latency: 1 IDLE cycle to latch, then one beat per out_valid&&out_ready, then 1 DONE cycle; stalls hold all state.
module bus_xfer_ctrl #(
  parameter int N_MASTERS = 3,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 4,
  localparam int IDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_MASTERS-1:0]          bus_grant,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data,
  input  logic [N_MASTERS*LEN_W-1:0]    m_len,
  output logic [N_MASTERS-1:0]          m_ready,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  output logic [IDX_W-1:0]              out_master,
  output logic                          bus_ack,
  output logic                          busy,
  output logic                          err_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_bus_ack;
  logic               r_err_grant;

  logic               w_grant_any;
  logic               w_grant_multi;
  logic               w_grant_one;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [LEN_W-1:0]   w_grant_len;
  logic               w_sel_valid;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_xfer;
  logic               w_beat;
  logic               w_last_cnt;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign w_grant_any   = (bus_grant != '0);
  assign w_grant_multi = ((bus_grant & (bus_grant - N_MASTERS'(1))) != '0);
  assign w_grant_one   = w_grant_any && !w_grant_multi;

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (bus_grant[i]) begin
        w_grant_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    w_grant_len = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_valid = m_valid[i];
        w_sel_data  = m_data[i*DATA_W +: DATA_W];
      end
      if (w_grant_idx == IDX_W'(i)) begin
        w_grant_len = m_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Gating with reset_n keeps every combinational output quiet while reset is held.
  assign w_xfer     = reset_n && (r_state == ST_XFER);
  assign w_beat     = w_xfer && w_sel_valid && out_ready;
  assign w_last_cnt = (r_beat_cnt == r_len);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_one) begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_beat && w_last_cnt) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_bus_ack   <= 1'b0;
      r_err_grant <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_ack   <= (r_state == ST_XFER) && w_beat && w_last_cnt;
      r_err_grant <= (r_state == ST_IDLE) && w_grant_multi;
      if ((r_state == ST_IDLE) && w_grant_one) begin
        r_idx      <= w_grant_idx;
        r_len      <= w_grant_len;
        r_beat_cnt <= '0;
      end else if (w_beat && !w_last_cnt) begin
        // The final beat leaves the count at len_q, so it can never wrap mid-burst.
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
      end
    end
  end

  always_comb begin
    m_ready = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_ready[i] = w_xfer && (r_idx == IDX_W'(i)) && out_ready;
    end
  end

  assign out_valid  = w_xfer && w_sel_valid;
  assign out_data   = w_xfer ? w_sel_data : '0;
  assign out_last   = w_xfer && w_last_cnt;
  assign out_master = r_idx;
  assign bus_ack    = r_bus_ack;
  assign err_grant  = r_err_grant;
  assign busy       = reset_n && ((r_state == ST_XFER) || (r_state == ST_DONE));

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed vector table, random bursts against a transaction-level model,
// plus mid-burst reset and a closed loop with a simple priority arbiter.
module tb_bus_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  bus_grant;
  logic [2:0]  m_valid;
  logic [23:0] m_data;
  logic [11:0] m_len;
  logic [2:0]  m_ready;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_master;
  logic        bus_ack;
  logic        busy;
  logic        err_grant;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus_grant  (bus_grant),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_len      (m_len),
    .m_ready    (m_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_master (out_master),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .err_grant  (err_grant)
  );

  typedef struct {
    logic [2:0] grant;
    logic [3:0] len;
    int         mode;       // 0 full rate, 1 random stalls + input churn, 2 fixed stall pattern
    int         exp_beats;
    bit         exp_err;
    bit         exp_ack;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int pop3(input logic [2:0] g);
    return int'(g[0]) + int'(g[1]) + int'(g[2]);
  endfunction

  // Starts in an IDLE cycle at posedge+1 and returns in the following IDLE cycle.
  task automatic do_burst(input logic [2:0] g, input logic [3:0] len, input int mode,
                          output int beats, output bit err_seen, output bit ack_seen);
    int         idx;
    bit         done;
    logic [7:0] exp_d;
    beats    = 0;
    err_seen = 1'b0;
    ack_seen = 1'b0;
    bus_grant = g;
    m_len     = {len, len, len};
    m_valid   = 3'b111;
    out_ready = 1'b1;
    m_data    = 24'($urandom);
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_mready", 32'(m_ready), 0);
    step;
    if (pop3(g) != 1) begin
      err_seen = err_grant;
      ack_seen = bus_ack;
      chk("nostart_busy", 32'(busy), 0);
      bus_grant = 3'b000;
      step;
      chk("err_pulse_width", 32'(err_grant), 0);
      return;
    end
    idx  = g[0] ? 0 : (g[1] ? 1 : 2);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      case (mode)
        1: begin
          m_valid   = 3'($urandom);
          out_ready = ($urandom_range(3) != 0);
          m_len     = 12'($urandom);
          if ($urandom_range(1) == 1) bus_grant = 3'($urandom);
        end
        2: begin
          out_ready = (c % 2 == 0);
          m_valid   = (c == 1 || c == 2) ? 3'b101 : 3'b111;
        end
        default: begin
          m_valid   = 3'b111;
          out_ready = 1'b1;
        end
      endcase
      m_data = 24'($urandom);
      #1;
      exp_d = 8'(m_data >> (8 * idx));
      chk("xfer_busy", 32'(busy), 1);
      chk("xfer_master", 32'(out_master), 32'(idx));
      chk("xfer_valid", 32'(out_valid), 32'(m_valid[idx]));
      chk("xfer_data", 32'(out_data), 32'(exp_d));
      chk("xfer_mready", 32'(m_ready), 32'((3'b001 << idx) & {3{out_ready}}));
      chk("xfer_last", 32'(out_last), 32'(beats == int'(len)));
      if (m_valid[idx] && out_ready) begin
        beats++;
        if (beats == int'(len) + 1) done = 1'b1;
      end
      step;
    end
    if (!done) begin
      chk("burst_timeout", 32'(beats), 32'(int'(len) + 1));
      return;
    end
    bus_grant = 3'b000;
    m_valid   = 3'b111;
    out_ready = 1'b1;
    #1;
    ack_seen = bus_ack;
    chk("done_busy", 32'(busy), 1);
    chk("done_valid", 32'(out_valid), 0);
    chk("done_mready", 32'(m_ready), 0);
    chk("done_last", 32'(out_last), 0);
    step;
    chk("ack_width", 32'(bus_ack), 0);
    chk("back_idle", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[9];
    int         beats;
    bit         err_s;
    bit         ack_s;
    logic [2:0] g;
    logic [3:0] len;
    int         acks;
    bit         last_ack;
    bit         req0;
    logic [2:0] arb_g;

    vecs[0] = '{3'b001, 4'd3,  0, 4,  1'b0, 1'b1};
    vecs[1] = '{3'b100, 4'd0,  0, 1,  1'b0, 1'b1};
    vecs[2] = '{3'b010, 4'd2,  2, 3,  1'b0, 1'b1};
    vecs[3] = '{3'b011, 4'd5,  0, 0,  1'b1, 1'b0};
    vecs[4] = '{3'b000, 4'd5,  0, 0,  1'b0, 1'b0};
    vecs[5] = '{3'b111, 4'd1,  0, 0,  1'b1, 1'b0};
    vecs[6] = '{3'b010, 4'd15, 0, 16, 1'b0, 1'b1};
    vecs[7] = '{3'b001, 4'd0,  0, 1,  1'b0, 1'b1};
    vecs[8] = '{3'b001, 4'd5,  1, 6,  1'b0, 1'b1};

    reset_n   = 1'b0;
    bus_grant = 3'b001;
    m_valid   = 3'b111;
    m_data    = 24'h0;
    m_len     = 12'h0;
    out_ready = 1'b1;
    step;
    step;
    chk("rst_ack", 32'(bus_ack), 0);
    chk("rst_err", 32'(err_grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_mready", 32'(m_ready), 0);
    chk("rst_master", 32'(out_master), 0);
    chk("rst_data", 32'(out_data), 0);
    bus_grant = 3'b000;
    reset_n   = 1'b1;
    step;

    for (int v = 0; v < 9; v++) begin
      do_burst(vecs[v].grant, vecs[v].len, vecs[v].mode, beats, err_s, ack_s);
      chk("vec_beats", 32'(beats), 32'(vecs[v].exp_beats));
      chk("vec_err", 32'(err_s), 32'(vecs[v].exp_err));
      chk("vec_ack", 32'(ack_s), 32'(vecs[v].exp_ack));
    end

    for (int r = 0; r < 40; r++) begin
      g   = ($urandom_range(5) == 0) ? 3'($urandom) : (3'b001 << $urandom_range(2));
      len = 4'($urandom);
      do_burst(g, len, 1, beats, err_s, ack_s);
      chk("rnd_beats", 32'(beats), (pop3(g) == 1) ? 32'(int'(len) + 1) : 32'd0);
      chk("rnd_ack", 32'(ack_s), 32'(pop3(g) == 1));
      chk("rnd_err", 32'(err_s), 32'(pop3(g) > 1));
    end

    // Reset in the middle of an 8-beat burst from master 0.
    bus_grant = 3'b001;
    m_len     = 12'h007;
    m_valid   = 3'b111;
    out_ready = 1'b1;
    step;
    for (int b = 0; b < 3; b++) begin
      chk("pre_rst_valid", 32'(out_valid), 1);
      step;
    end
    reset_n = 1'b0;
    #1;
    chk("inrst_valid", 32'(out_valid), 0);
    chk("inrst_mready", 32'(m_ready), 0);
    chk("inrst_busy", 32'(busy), 0);
    step;
    chk("postrst_ack", 32'(bus_ack), 0);
    chk("postrst_master", 32'(out_master), 0);
    chk("postrst_last", 32'(out_last), 0);
    step;
    chk("heldrst_busy", 32'(busy), 0);
    chk("heldrst_ack", 32'(bus_ack), 0);
    bus_grant = 3'b000;
    reset_n   = 1'b1;
    step;
    do_burst(3'b001, 4'd3, 0, beats, err_s, ack_s);
    chk("afterrst_beats", 32'(beats), 4);
    chk("afterrst_ack", 32'(ack_s), 1);

    // Closed loop: fixed-priority arbiter re-evaluates on the edge that ends DONE.
    acks     = 0;
    last_ack = 1'b0;
    req0     = 1'b1;
    arb_g    = 3'b001;
    m_len    = {4'd0, 4'd2, 4'd1};
    out_ready = 1'b1;
    for (int c = 0; c < 120 && acks < 6; c++) begin
      if (last_ack) arb_g = req0 ? 3'b001 : 3'b010;
      bus_grant = arb_g;
      m_valid   = {1'b0, 1'b1, req0};
      m_data    = 24'($urandom);
      #1;
      if (bus_ack) begin
        chk("arb_owner", 32'(out_master), (acks < 3) ? 32'd0 : 32'd1);
        acks++;
        if (acks == 3) req0 = 1'b0;
      end
      last_ack = bus_ack;
      step;
    end
    chk("arb_acks", 32'(acks), 6);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter N_MASTERS, default 3: number of bus masters, equal to the arbiter's master count.
REQ-002 Parameter DATA_W, default 8: beat data width in bits.
REQ-003 Parameter LEN_W, default 4: burst length field width; field value L means L+1 beats.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 bus_grant  input  N_MASTERS  one-hot grant from the bus arbiter.
REQ-007 m_valid  input  N_MASTERS  per-master beat-valid.
REQ-008 m_data  input  N_MASTERS*DATA_W  per-master data; master i occupies bits [i*DATA_W +: DATA_W].
REQ-009 m_len  input  N_MASTERS*LEN_W  per-master burst length; master i occupies bits [i*LEN_W +: LEN_W].
REQ-010 m_ready  output  N_MASTERS  per-master beat accept.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_valid  output  1  downstream beat valid.
REQ-013 out_data  output  DATA_W  downstream beat data.
REQ-014 out_last  output  1  marks the final beat of a burst.
REQ-015 out_master  output  $clog2(N_MASTERS)  index of the owning master, held for the whole burst.
REQ-016 bus_ack  output  1  registered one-cycle pulse to the arbiter marking burst completion.
REQ-017 busy  output  1  high in XFER and DONE.
REQ-018 err_grant  output  1  registered one-cycle pulse on a malformed grant.

Function
REQ-019 The FSM SHALL have three states: IDLE, XFER and DONE.
REQ-020 IDLE, bus_grant exactly one-hot: on the next edge, latch the index into out_master and the index's m_len into len_q, clear beat_cnt, and go to XFER.
REQ-021 IDLE, bus_grant == 0: remain in IDLE with no other action.
REQ-022 IDLE, bus_grant with two or more bits set: remain in IDLE, pulse err_grant for one cycle, and latch nothing.
REQ-023 XFER outputs (combinational from the latched index idx):
- out_valid = m_valid[idx]
- out_data = m_data slice idx
- m_ready[idx] = out_ready
- all other m_ready bits = 0
REQ-024 A beat SHALL transfer when out_valid and out_ready are both high; beat_cnt increments by 1 on each beat.
REQ-025 out_last SHALL be high when in XFER and beat_cnt == len_q.
REQ-026 A beat with out_last high SHALL move the FSM to DONE on the next edge.
REQ-027 Stall: with m_valid[idx] or out_ready low, the block holds state and beat_cnt and completes no beat.
REQ-028 DONE: bus_ack = 1 for exactly one cycle; next state is IDLE unconditionally.
REQ-029 The arbiter updates bus_grant on the edge that ends DONE, so IDLE evaluates the updated grant.
REQ-030 Back-to-back bursts by the same master SHALL be permitted: IDLE, then XFER again.
REQ-031 In DONE and IDLE: out_valid, out_last and all m_ready bits SHALL be 0.
REQ-032 In XFER and DONE, changes on bus_grant SHALL be ignored; the latched idx governs the burst.
REQ-033 Changes on m_len during a burst SHALL be ignored; len_q is fixed for the burst.
REQ-034 Length boundaries:
- m_len = 0 gives a 1-beat burst, with out_last on the first beat.
- m_len = 2^LEN_W-1 gives 2^LEN_W beats.
- beat_cnt SHALL NOT wrap within a burst.
REQ-035 Minimum burst occupancy SHALL be 1 IDLE evaluation cycle, then L+1 XFER cycles, then 1 DONE cycle.

Reset
REQ-036 With reset_n low at a clock edge, the block SHALL reset to: state IDLE, beat_cnt 0, len_q 0, out_master 0, bus_ack 0, err_grant 0.
REQ-037 While in reset, all combinational outputs SHALL be 0.
REQ-038 A reset asserted during XFER or DONE SHALL abort the burst with no bus_ack pulse.
REQ-039 After reset_n rises, the first grant evaluation SHALL occur in the next IDLE cycle.

Verification
REQ-040 Grant 3'b001, m_len[0]=3, m_valid and out_ready held high -> 4 beats carrying m_data[0]; out_last on beat 4; bus_ack high in the cycle after beat 4; out_master=0.
REQ-041 Grant 3'b100, m_len[2]=0 -> a single beat with out_last=1; bus_ack one cycle later; m_ready=3'b100 during the beat.
REQ-042 Grant 3'b010, m_len[1]=2, out_ready low on alternate cycles and m_valid[1] low for 2 cycles -> exactly 3 beats; beat_cnt frozen during stalls; bus_ack after beat 3 only.
REQ-043 Grant 3'b011 in IDLE -> err_grant pulse; no XFER; no bus_ack; state stays IDLE.
REQ-044 Master 0 bursting with m_len=7, reset_n low after beat 3 -> outputs cleared on that edge; no bus_ack; a fresh grant afterwards starts at beat_cnt 0.
REQ-045 Closed loop with the arbiter, masters 0 and 1 requesting continuously -> master 0 served repeatedly; master 1 served only after master 0 drops its request; bus_grant one-hot at all times.
